// File: rtl/timer_flag_bank.sv
// rtl/timer_flag_bank.sv - bank of independent one-shot/periodic timers with sticky flags and tick pulses
module timer_flag_bank #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_limit,
    input  logic              cfg_periodic,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] flag,
    output logic [NUM_CH-1:0] tick
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        state_t            state;
        logic [CNT_W-1:0]  limit_q;
        logic              mode_q;
        logic [CNT_W-1:0]  act_limit_q;
        logic              act_mode_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              flag_q;
        logic              tick_q;

        logic              wr;
        logic [CNT_W-1:0]  new_limit;
        logic              new_mode;
        logic [CNT_W-1:0]  load_limit;

        // Same-cycle config writes are forwarded so a start/reload sees the new values.
        assign wr         = cfg_we && (cfg_ch == CH_W'(i));
        assign new_limit  = wr ? cfg_limit : limit_q;
        assign new_mode   = wr ? cfg_periodic : mode_q;
        assign load_limit = (new_limit == '0) ? ONE : new_limit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state       <= IDLE;
                limit_q     <= ONE;
                mode_q      <= 1'b0;
                act_limit_q <= ONE;
                act_mode_q  <= 1'b0;
                cnt_q       <= '0;
                flag_q      <= 1'b0;
                tick_q      <= 1'b0;
            end else begin
                if (wr) begin
                    limit_q <= cfg_limit;
                    mode_q  <= cfg_periodic;
                end
                tick_q <= 1'b0;
                if (stop[i]) begin
                    state  <= IDLE;
                    cnt_q  <= '0;
                    flag_q <= 1'b0;
                end else if (start[i]) begin
                    state       <= RUN;
                    act_limit_q <= load_limit;
                    act_mode_q  <= new_mode;
                    cnt_q       <= '0;
                    flag_q      <= 1'b0;
                end else if (state == RUN) begin
                    if (cnt_q == act_limit_q - ONE) begin
                        tick_q <= 1'b1;
                        flag_q <= 1'b1;
                        cnt_q  <= '0;
                        if (act_mode_q) begin
                            act_limit_q <= load_limit;
                            act_mode_q  <= new_mode;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
            end
        end

        assign busy[i] = (state == RUN);
        assign flag[i] = flag_q;
        assign tick[i] = tick_q;
    end

endmodule

// File: tb/tb_timer_flag_bank.sv
// tb/tb_timer_flag_bank.sv - self-checking bench for timer_flag_bank
module tb_timer_flag_bank;
    localparam int NCH = 6;
    localparam int CW  = 16;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_limit;
    logic           cfg_periodic;
    logic [NCH-1:0] start, stop, busy, flag, tick;

    always #5 clk = ~clk;

    timer_flag_bank #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_limit(cfg_limit), .cfg_periodic(cfg_periodic),
        .start(start), .stop(stop), .busy(busy), .flag(flag), .tick(tick)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: remaining-cycle countdown per channel.
    int             m_lim [NCH];
    int             m_rem [NCH];
    logic [NCH-1:0] m_mode, m_amode, m_run, m_flag, m_tick;

    typedef struct {
        logic           we;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  lim;
        logic           per;
        logic [NCH-1:0] st;
        logic [NCH-1:0] sp;
        logic [NCH-1:0] e_busy;
        logic [NCH-1:0] e_flag;
        logic [NCH-1:0] e_tick;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lim[c] = 1;
            m_rem[c] = 0;
        end
        m_mode = '0; m_amode = '0; m_run = '0; m_flag = '0; m_tick = '0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int nl;
            int eff;
            logic nm;
            logic wr;
            wr  = cfg_we && (int'(cfg_ch) == c);
            nl  = wr ? int'(cfg_limit) : m_lim[c];
            nm  = wr ? cfg_periodic : m_mode[c];
            eff = (nl == 0) ? 1 : nl;
            m_tick[c] = 1'b0;
            if (stop[c]) begin
                m_run[c]  = 1'b0;
                m_flag[c] = 1'b0;
            end else if (start[c]) begin
                m_run[c]   = 1'b1;
                m_rem[c]   = eff;
                m_amode[c] = nm;
                m_flag[c]  = 1'b0;
            end else if (m_run[c]) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_flag[c] = 1'b1;
                    if (m_amode[c]) begin
                        m_rem[c]   = eff;
                        m_amode[c] = nm;
                    end else begin
                        m_run[c] = 1'b0;
                    end
                end
            end
            m_lim[c]  = nl;
            m_mode[c] = nm;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_busy", busy, m_run);
        check("model_flag", flag, m_flag);
        check("model_tick", tick, m_tick);
    endtask

    task automatic cfg(input int ch, input int lim, input logic per);
        cfg_we       = 1'b1;
        cfg_ch       = CHW'(ch);
        cfg_limit    = CW'(lim);
        cfg_periodic = per;
    endtask

    task automatic idle();
        cfg_we = 1'b0;
        start  = '0;
        stop   = '0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'd0, 16'd5, 1'b0, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        tbl[1] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h01, 6'h00, 6'h01, 6'h00, 6'h00};
        tbl[2] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00};
        tbl[3] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00};
        tbl[4] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00};
        tbl[5] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00};
        tbl[6] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h00, 6'h00, 6'h00, 6'h01, 6'h01};
        tbl[7] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h00, 6'h00, 6'h00, 6'h01, 6'h00};
        tbl[8] = '{1'b0, 3'd0, 16'd0, 1'b0, 6'h00, 6'h00, 6'h00, 6'h01, 6'h00};

        rst_n = 1'b0;
        cfg_ch = '0; cfg_limit = '0; cfg_periodic = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_flag", flag, 0);
        check("reset_tick", tick, 0);

        // One-shot limit 5 on ch0, table driven
        for (int r = 0; r < 9; r++) begin
            cfg_we = tbl[r].we; cfg_ch = tbl[r].ch;
            cfg_limit = tbl[r].lim; cfg_periodic = tbl[r].per;
            start = tbl[r].st; stop = tbl[r].sp;
            cycle();
            check($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            check($sformatf("tbl%0d_flag", r), flag, tbl[r].e_flag);
            check($sformatf("tbl%0d_tick", r), tick, tbl[r].e_tick);
        end
        idle();

        // Periodic limit 3 on ch2
        cfg(2, 3, 1'b1); cycle(); idle();
        start = 6'b000100; cycle(); start = '0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check($sformatf("per_tick_k%0d", k), tick[2], (k % 3 == 0));
            check($sformatf("per_busy_k%0d", k), busy[2], 1);
        end
        stop = 6'b000100; cycle(); stop = '0;
        check("per_stop_busy", busy[2], 0);
        check("per_stop_flag", flag[2], 0);
        check("per_stop_tick", tick[2], 0);

        // Limit 0 behaves as 1; start+stop together
        cfg(1, 0, 1'b0); start = 6'b000010; cycle(); idle();
        check("lim0_busy", busy[1], 1);
        cycle();
        check("lim0_tick", tick[1], 1);
        check("lim0_done", busy[1], 0);
        cycle();
        check("lim0_flag_held", flag[1], 1);
        check("lim0_tick_once", tick[1], 0);
        start = 6'b000010; stop = 6'b000010; cycle(); idle();
        check("ststp_busy", busy[1], 0);
        check("ststp_flag", flag[1], 0);
        cycle();
        check("ststp_stay_idle", busy[1], 0);

        // Write and start together: the new limit is latched
        cfg(4, 4, 1'b0); start = 6'b010000; cycle(); idle();
        for (int k = 1; k <= 5; k++) begin
            cycle();
            check($sformatf("fwd_tick_k%0d", k), tick[4], (k == 4));
        end

        // Rewriting the limit mid-count does not disturb the running count
        cfg(3, 10, 1'b0); cycle(); idle();
        start = 6'b001000; cycle(); start = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) cfg(3, 2, 1'b0);
            cycle();
            cfg_we = 1'b0;
            check($sformatf("rw_tick_k%0d", k), tick[3], (k == 10));
        end
        start = 6'b001000; cycle(); start = '0;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            check($sformatf("rw2_tick_k%0d", k), tick[3], (k == 2));
        end

        // Asynchronous reset mid-count
        cfg(0, 8, 1'b0); cycle(); idle();
        start = 6'b000001; cycle(); start = '0;
        repeat (3) cycle();
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_flag", flag, 0);
        check("arst_tick", tick, 0);
        model_reset();
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check($sformatf("arst_notick_k%0d", k), tick, 0);
        end

        // Out-of-range channel write is ignored; limits stay at reset value 1
        cfg(NCH, 3, 1'b1); cycle(); idle();
        start = '1; cycle(); start = '0;
        check("oor_busy", busy, {NCH{1'b1}});
        cycle();
        check("oor_tick", tick, {NCH{1'b1}});
        check("oor_done", busy, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            cfg_we       = ($urandom_range(0, 3) == 0);
            cfg_ch       = CHW'($urandom_range(0, 7));
            cfg_limit    = CW'($urandom_range(0, 6));
            cfg_periodic = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCH; c++) begin
                start[c] = ($urandom_range(0, 15) == 0);
                stop[c]  = ($urandom_range(0, 31) == 0);
            end
            cycle();
        end
        idle();
        repeat (10) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/timer_flag_bank.md
TIMER_FLAG_BANK -- requirements
Module: timer_flag_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of each channel's counter and limit.
REQ-003 SHALL have parameter CH_W, default 3, channel-index width; 2^CH_W >= NUM_CH is required.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_we  input  1  configuration write strobe, sampled each cycle.
REQ-007 SHALL have port cfg_ch  input  CH_W  channel index of the configuration write.
REQ-008 SHALL have port cfg_limit  input  CNT_W  expiry length in clk cycles.
REQ-009 SHALL have port cfg_periodic  input  1  mode bit: 1 = periodic, 0 = one-shot.
REQ-010 SHALL have port start  input  NUM_CH  per-channel start/restart pulses.
REQ-011 SHALL have port stop  input  NUM_CH  per-channel abort pulses.
REQ-012 SHALL have port busy  output  NUM_CH  high while the channel is in RUN.
REQ-013 SHALL have port flag  output  NUM_CH  sticky expiry flag, registered.
REQ-014 SHALL have port tick  output  NUM_CH  one-cycle pulse on each expiry, registered.

Function
REQ-015 SHALL hold, per channel, a limit register, mode register, active-limit copy, counter, and a 3-state FSM: IDLE, RUN, DONE.
REQ-016 cfg_we=1 with cfg_ch < NUM_CH SHALL write cfg_limit and cfg_periodic into that channel's limit/mode registers on the same edge; writes with cfg_ch >= NUM_CH SHALL be ignored.
REQ-017 A configuration write SHALL NOT alter a running count; the active-limit copy and mode SHALL be latched only at start or periodic reload.
REQ-018 A stored limit of 0 SHALL be treated as 1.
REQ-019 start[i] sampled in any state SHALL: latch the active limit, clear the counter to 0, clear flag[i], and enter RUN.
REQ-020 If start[i] coincides with a configuration write to channel i, the newly written limit and mode SHALL be the ones latched.
REQ-021 In RUN the counter SHALL increment by 1 per cycle; at the edge where counter == active_limit-1, tick[i] and flag[i] SHALL be set.
REQ-022 tick[i] SHALL be high for exactly one cycle, first visible active_limit cycles after the edge that sampled start[i].
REQ-023 One-shot mode at expiry SHALL enter DONE and deassert busy[i]; flag[i] SHALL remain 1 until the next start or stop.
REQ-024 Periodic mode at expiry SHALL reload the counter to 0, re-latch the limit and mode, stay in RUN, and pulse tick[i] every active_limit cycles; flag[i] stays 1.
REQ-025 stop[i] SHALL return the channel to IDLE, clear counter, flag[i] and tick[i], and override a simultaneous start[i] or expiry.
REQ-026 The counter SHALL never exceed active_limit-1, so no wrap-around occurs for any CNT_W.
REQ-027 Channels SHALL be fully independent; events on one channel SHALL not affect any other.

Reset
REQ-028 rst_n=0 SHALL immediately clear, without a clock, all FSMs to IDLE, all counters to 0, busy/flag/tick to 0, all limit registers to 1, and all mode registers to 0.
REQ-029 Reset asserted mid-count SHALL abort the count with no tick produced; after release, channels stay IDLE until started.

Verification
REQ-030 Write ch0 limit=5 one-shot, start[0] -> busy[0]=1 for 5 cycles, tick[0] single pulse 5 cycles after start, flag[0]=1 held, busy[0]=0.
REQ-031 Write ch2 limit=3 periodic, start[2], run 12 cycles -> tick[2] pulses at cycles 3,6,9,12, busy[2] stays 1, then stop[2] -> flag/busy/tick all 0.
REQ-032 Write ch1 limit=0, start[1] -> tick[1] one cycle later; start[1] and stop[1] in the same cycle -> IDLE, flag[1]=0.
REQ-033 ch3 running with limit=10; at cycle 4 rewrite limit=2 -> expiry still at cycle 10; restart -> expiry at cycle 2.
REQ-034 ch0 at count 3 of 8, drive rst_n=0 for one half-cycle -> outputs 0 immediately, no tick after release; cfg_ch=NUM_CH write -> no register changes.
